mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 31 +++
 rtl/mux_scan_sequencer_seq_timer.sv | 26 ++
 rtl/mux_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and default constants for the mux scan sequencer
package mux_scan_pkg;

    localparam int CH_W            = 5;
    localparam int DEF_NUM_CH      = 18;
    localparam int DEF_ADC_W       = 12;
    localparam int DEF_SW_PULSE    = 2;
    localparam int DEF_SW_GAP      = 2;
    localparam int DEF_SETTLE_CYC  = 32;
    localparam int DEF_ADC_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        SW_HI,
        SW_LO,
        SETTLE,
        CONV,
        WAIT_ADC,
        OUTPUT
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that parks at zero and flags it
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // A load always wins; otherwise count down and hold at zero until reloaded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: per-frame channel scan driving the mux switcher and ADC, with a valid/ready sample output
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ADC_W       = DEF_ADC_W,
    parameter int SW_PULSE    = DEF_SW_PULSE,
    parameter int SW_GAP      = DEF_SW_GAP,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             clr_err,
    output logic             mux_switch,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [ADC_W-1:0] out_data,
    output logic             out_err,
    output logic             frame_done,
    output logic             busy,
    output logic             missed_start,
    output logic             adc_timeout
);

    localparam int TW = $clog2(max4(SETTLE_CYC, ADC_TIMEOUT, SW_PULSE, SW_GAP) + 1);

    state_t          state;
    logic [CH_W-1:0] ch;
    logic            zero;
    logic            xfer;
    logic            last;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;

    assign xfer   = (state == OUTPUT) && out_ready;
    assign last   = (ch == CH_W'(NUM_CH - 1));
    assign out_ch = ch;

    // Timer reload points: entering each timed phase, and arming the ADC timeout in CONV
    always_comb begin
        tmr_load = (state == IDLE && start && enable) || (state == SW_HI && zero) ||
                   (state == SW_LO && zero) || (state == CONV) || (xfer && !last && enable);
        tmr_val  = (state == SW_HI) ? TW'(SW_GAP - 1) :
                   (state == SW_LO) ? TW'(SETTLE_CYC - 1) :
                   (state == CONV)  ? TW'(ADC_TIMEOUT) : TW'(SW_PULSE - 1);
    end

    seq_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (zero)
    );

    // Scan FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ch           <= '0;
            mux_switch   <= 1'b0;
            adc_start    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_err      <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            missed_start <= 1'b0;
            adc_timeout  <= 1'b0;
        end else begin
            adc_start  <= 1'b0;
            frame_done <= 1'b0;
            if (clr_err) begin
                missed_start <= 1'b0;
                adc_timeout  <= 1'b0;
            end
            case (state)
                IDLE: if (start && enable) begin
                    ch         <= '0;
                    state      <= SW_HI;
                    mux_switch <= 1'b1;
                    busy       <= 1'b1;
                end
                SW_HI: if (zero) begin
                    state      <= SW_LO;
                    mux_switch <= 1'b0;
                end
                SW_LO: if (zero) state <= SETTLE;
                SETTLE: if (zero) state <= CONV;
                CONV: begin
                    adc_start <= 1'b1;
                    state     <= WAIT_ADC;
                end
                WAIT_ADC: if (adc_done) begin
                    out_data  <= adc_data;
                    out_err   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end else if (zero) begin
                    out_data    <= '1;
                    out_err     <= 1'b1;
                    adc_timeout <= 1'b1;
                    out_valid   <= 1'b1;
                    state       <= OUTPUT;
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else if (enable) begin
                        ch         <= ch + 1'b1;
                        state      <= SW_HI;
                        mux_switch <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start && state != IDLE) missed_start <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed and randomized frames checked against a sample scoreboard
module tb_mux_scan_sequencer;

    localparam int NCH = 4;
    localparam int AW  = 12;

    typedef struct {
        logic [AW-1:0] data;
        logic          err;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          enable = 1'b1;
    logic          clr_err = 1'b0;
    logic          mux_switch;
    logic          adc_start;
    logic          adc_done;
    logic [AW-1:0] adc_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    out_ch;
    logic [AW-1:0] out_data;
    logic          out_err;
    logic          frame_done;
    logic          busy;
    logic          missed_start;
    logic          adc_timeout;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   resp_idx = 0;
    int   mute_ch = -1;
    bit   fixed_data = 1'b1;
    bit   rnd_delay = 1'b0;
    bit   stray = 1'b0;

    mux_scan_sequencer #(
        .NUM_CH      (NCH),
        .ADC_W       (AW),
        .SW_PULSE    (2),
        .SW_GAP      (2),
        .SETTLE_CYC  (4),
        .ADC_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable       (enable),
        .clr_err      (clr_err),
        .mux_switch   (mux_switch),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .out_err      (out_err),
        .frame_done   (frame_done),
        .busy         (busy),
        .missed_start (missed_start),
        .adc_timeout  (adc_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: answers each conversion after a delay and records what the sequencer must report
    initial begin
        int cnt = 0;
        int d;
        logic [AW-1:0] pend = '0;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            adc_data = AW'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = pend;
                end
            end else if (stray && mux_switch && $urandom_range(0, 2) == 0) begin
                adc_done = 1'b1;
            end
            if (adc_start) begin
                if (resp_idx == mute_ch) begin
                    exp_q.push_back('{data: '1, err: 1'b1, lat: -1});
                end else begin
                    d    = rnd_delay ? int'($urandom_range(1, 5)) : 3;
                    pend = fixed_data ? AW'(12'h100 + resp_idx) : AW'($urandom);
                    cnt  = d;
                    exp_q.push_back('{data: pend, err: 1'b0, lat: 10 + d});
                end
                resp_idx++;
            end
        end
    end

    task automatic run_frame(input int stall_ch, input bit rnd_ready, input int drop_ch, input int start_ch);
        int exp_ch = 0, edges = 0, since = 0, stall = 0, cyc = 0;
        bit prev_sw = 0, xfer = 0, done = 0, seen = 0, trunc = 0;
        exp_q.delete();
        resp_idx = 0;
        enable = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 2000) begin
            if (xfer) begin
                chk("valid_drop", 32'(out_valid), 0);
                chk("frame_done", 32'(frame_done), 32'(exp_ch == NCH - 1));
                if (exp_ch == NCH - 1 || trunc) begin
                    done = 1;
                    chk("busy_end", 32'(busy), 0);
                end
                exp_ch++;
                xfer = 0;
                seen = 0;
            end
            if (mux_switch && !prev_sw) begin
                edges++;
                since = 0;
            end else since++;
            prev_sw = mux_switch;
            start = (exp_ch == start_ch && since == 3);
            if (exp_ch == drop_ch && since == 5 && !seen) begin
                enable = 1'b0;
                trunc = 1;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!done && out_valid) begin
                chk("queued", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    if (!seen && exp_q[0].lat >= 0) chk("latency", since, exp_q[0].lat);
                    seen = 1;
                    chk("out_ch", 32'(out_ch), exp_ch);
                    chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                    chk("out_err", 32'(out_err), 32'(exp_q[0].err));
                    chk("switch_quiet", 32'(mux_switch), 0);
                    if (exp_ch == stall_ch && stall < 10) begin
                        out_ready = 1'b0;
                        stall++;
                    end
                    if (out_ready) begin
                        xfer = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("frame_finished", 32'(done), 1);
        chk("frame_done_pulse", 32'(frame_done), 0);
        chk("switch_edges", edges, exp_ch);
        chk("channels", exp_ch, drop_ch >= 0 ? drop_ch + 1 : NCH);
        enable = 1'b1;
        out_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_timeout", 32'(adc_timeout), 0);
        chk("clr_missed", 32'(missed_start), 0);
    endtask

    initial begin
        #1;
        chk("reset_outs", 32'({mux_switch, adc_start, out_valid, out_ch, out_data, out_err,
                                frame_done, busy, missed_start, adc_timeout}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_frame(-1, 0, -1, -1);
        chk("no_missed", 32'(missed_start), 0);
        chk("no_timeout", 32'(adc_timeout), 0);

        run_frame(1, 0, -1, 1);
        chk("missed_start", 32'(missed_start), 1);

        enable = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_disabled_busy", 32'(busy), 0);
        chk("idle_disabled_sw", 32'(mux_switch), 0);
        chk("missed_sticky", 32'(missed_start), 1);
        enable = 1'b1;

        mute_ch = 2;
        run_frame(-1, 0, -1, -1);
        mute_ch = -1;
        chk("timeout_flag", 32'(adc_timeout), 1);
        pulse_clr();

        run_frame(-1, 0, 1, -1);
        chk("trunc_busy", 32'(busy), 0);

        begin
            int e = 0, s = 0, g = 0;
            bit p = 0;
            exp_q.delete();
            resp_idx = 0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!(e == 3 && s == 5) && g < 500) begin
                if (mux_switch && !p) begin
                    e++;
                    s = 0;
                end else s++;
                p = mux_switch;
                @(negedge clk);
                g++;
            end
            chk("reach_ch2", 32'(g < 500), 1);
            chk("busy_before_reset", 32'(busy), 1);
            reset = 1'b0;
            #1;
            chk("reset_mid_frame", 32'({mux_switch, adc_start, out_valid, out_ch, out_data, out_err,
                                         frame_done, busy, missed_start, adc_timeout}), 0);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
        end
        run_frame(-1, 0, -1, -1);

        fixed_data = 1'b0;
        rnd_delay = 1'b1;
        stray = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int drop;
            mute_ch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NCH - 1)) : -1;
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NCH - 2)) : -1;
            run_frame(-1, 1, drop, -1);
            chk("rnd_timeout_flag", 32'(adc_timeout),
                32'(mute_ch >= 0 && mute_ch < (drop >= 0 ? drop + 1 : NCH)));
            pulse_clr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
